fir_sample_feeder: RTL and testbench

FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

---
 rtl/fir_pkg.sv | 14 +
 rtl/fir_sample_feeder.sv | 170 +++++++++++++++++
 tb/tb_fir_sample_feeder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared sizes and state encoding for the FIR sample feeder
package fir_pkg;

    localparam int DEPTH    = 64;
    localparam int IDX_W    = 6;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START     = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fir_sample_feeder.sv
// rtl/fir_sample_feeder.sv - ring buffer feeding audio samples to a FIR engine
//
// Purpose: stores incoming samples in a 64-entry ring, pulses ready_out to
// start the filter, waits for done_in (or a timeout), latches the result and
// holds at most one sample pending while the filter is busy.
//
// Ports:
//   clk_in          system clock, rising edge
//   rst_n_in        asynchronous active-low reset
//   sample_valid_in one-cycle strobe, sample_in holds a new sample
//   sample_in       signed audio sample
//   sample_out      ring buffer contents, index 0..63
//   offset_out      ring index of the newest sample
//   ready_out       one-cycle start pulse to the filter
//   done_in         filter completion pulse
//   filt_in         filter result, valid with done_in
//   filt_out        latched filter result
//   filt_valid_out  one-cycle pulse, filt_out updated
//   overrun_out     one-cycle pulse, a sample was dropped
//   timeout_out     one-cycle pulse, filter failed to respond
//   overrun_cnt_out saturating count of dropped samples
module fir_sample_feeder
    import fir_pkg::*;
#(
    parameter int TIMEOUT = 127
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       sample_valid_in,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    output logic signed [SAMPLE_W-1:0] sample_out [DEPTH],
    output logic        [IDX_W-1:0]    offset_out,
    output logic                       ready_out,
    input  logic                       done_in,
    input  logic signed [SAMPLE_W-1:0] filt_in,
    output logic signed [SAMPLE_W-1:0] filt_out,
    output logic                       filt_valid_out,
    output logic                       overrun_out,
    output logic                       timeout_out,
    output logic        [7:0]          overrun_cnt_out
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t                     state, next_state;
    logic   [CNT_W-1:0]         wait_cnt;
    logic                       pend_full;
    logic signed [SAMPLE_W-1:0] pend_data;

    logic                       commit_en;
    logic signed [SAMPLE_W-1:0] commit_data;
    logic                       pend_load;
    logic                       pend_clear;
    logic                       drop;
    logic                       filt_latch;
    logic                       timeout_evt;
    logic                       finish;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        commit_en   = 1'b0;
        commit_data = sample_in;
        pend_load   = 1'b0;
        pend_clear  = 1'b0;
        drop        = 1'b0;
        filt_latch  = 1'b0;
        timeout_evt = 1'b0;
        finish      = 1'b0;
        ready_out   = 1'b0;

        case (state)
            IDLE: begin
                if (sample_valid_in) begin
                    commit_en  = 1'b1;
                    next_state = START;
                end
            end
            START: begin
                ready_out  = 1'b1;
                next_state = WAIT_DONE;
                if (sample_valid_in) begin
                    pend_load = !pend_full;
                    drop      = pend_full;
                end
            end
            WAIT_DONE: begin
                // A timeout finishes the wait exactly like done_in, minus the result latch.
                finish      = done_in || (wait_cnt == CNT_W'(TIMEOUT));
                filt_latch  = done_in;
                timeout_evt = !done_in && (wait_cnt == CNT_W'(TIMEOUT));
                if (finish) begin
                    if (pend_full) begin
                        commit_en   = 1'b1;
                        commit_data = pend_data;
                        next_state  = START;
                        // The new arrival refills the slot just vacated, so nothing is lost.
                        pend_load   = sample_valid_in;
                        pend_clear  = !sample_valid_in;
                    end else if (sample_valid_in) begin
                        commit_en  = 1'b1;
                        next_state = START;
                    end else begin
                        next_state = IDLE;
                    end
                end else if (sample_valid_in) begin
                    pend_load = !pend_full;
                    drop      = pend_full;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wait_cnt        <= '0;
            pend_full       <= 1'b0;
            pend_data       <= '0;
            offset_out      <= '0;
            filt_out        <= '0;
            filt_valid_out  <= 1'b0;
            overrun_out     <= 1'b0;
            timeout_out     <= 1'b0;
            overrun_cnt_out <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sample_out[i] <= '0;
            end
        end else begin
            // Counter restarts at 0 on every entry to WAIT_DONE.
            if (state == WAIT_DONE && next_state == WAIT_DONE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (pend_load) begin
                pend_full <= 1'b1;
                pend_data <= sample_in;
            end else if (pend_clear) begin
                pend_full <= 1'b0;
            end

            if (commit_en) begin
                offset_out                    <= offset_out + 1'b1;
                sample_out[offset_out + 1'b1] <= commit_data;
            end

            if (filt_latch) begin
                filt_out <= filt_in;
            end

            filt_valid_out <= filt_latch;
            overrun_out    <= drop;
            timeout_out    <= timeout_evt;

            if (drop && overrun_cnt_out != 8'hFF) begin
                overrun_cnt_out <= overrun_cnt_out + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_sample_feeder.sv
// tb/tb_fir_sample_feeder.sv - directed self-checking bench for fir_sample_feeder
module tb_fir_sample_feeder;

    logic               clk_in;
    logic               rst_n_in;
    logic               sample_valid_in;
    logic signed [15:0] sample_in;
    logic signed [15:0] sample_out [64];
    logic        [5:0]  offset_out;
    logic               ready_out;
    logic               done_in;
    logic signed [15:0] filt_in;
    logic signed [15:0] filt_out;
    logic               filt_valid_out;
    logic               overrun_out;
    logic               timeout_out;
    logic        [7:0]  overrun_cnt_out;

    int checks;
    int failures;

    fir_sample_feeder #(.TIMEOUT(127)) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .sample_valid_in (sample_valid_in),
        .sample_in       (sample_in),
        .sample_out      (sample_out),
        .offset_out      (offset_out),
        .ready_out       (ready_out),
        .done_in         (done_in),
        .filt_in         (filt_in),
        .filt_out        (filt_out),
        .filt_valid_out  (filt_valid_out),
        .overrun_out     (overrun_out),
        .timeout_out     (timeout_out),
        .overrun_cnt_out (overrun_cnt_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic apply_reset();
        rst_n_in        = 1'b0;
        sample_valid_in = 1'b0;
        sample_in       = '0;
        done_in         = 1'b0;
        filt_in         = '0;
        tick();
        tick();
        rst_n_in = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        apply_reset();
        bad = 0;
        for (int i = 0; i < 64; i++) if (sample_out[i] !== 16'sh0) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL reset_ring nonzero_entries=%0d expected=0", bad); end
        checks++;
        if ({offset_out, ready_out, filt_valid_out, overrun_out, timeout_out} !== 10'b0) begin
            failures++; $display("FAIL reset_ctrl offset=%0d ready=%b fv=%b ov=%b to=%b expected all 0",
                                 offset_out, ready_out, filt_valid_out, overrun_out, timeout_out);
        end
        checks++;
        if (filt_out !== 16'sh0 || overrun_cnt_out !== 8'd0) begin
            failures++; $display("FAIL reset_data filt=%h cnt=%0d expected 0/0", filt_out, overrun_cnt_out);
        end
    endtask

    task automatic test_single_sample();
        sample_valid_in = 1'b1;
        sample_in       = 16'sh1234;
        tick();
        sample_valid_in = 1'b0;
        checks++;
        if (offset_out !== 6'd1 || sample_out[1] !== 16'sh1234 || sample_out[0] !== 16'sh0) begin
            failures++; $display("FAIL single_commit offset=%0d s1=%h s0=%h expected 1/1234/0000",
                                 offset_out, sample_out[1], sample_out[0]);
        end
        checks++;
        if (ready_out !== 1'b1) begin failures++; $display("FAIL single_ready got=%b expected=1", ready_out); end
        tick();
        checks++;
        if (ready_out !== 1'b0) begin failures++; $display("FAIL single_ready_width got=%b expected=0", ready_out); end
    endtask

    task automatic test_done();
        // One cycle after ready already elapsed; 63 more puts done_in 64 cycles after ready.
        for (int i = 0; i < 63; i++) tick();
        done_in = 1'b1;
        filt_in = 16'sh0F00;
        tick();
        done_in = 1'b0;
        checks++;
        if (filt_out !== 16'sh0F00 || filt_valid_out !== 1'b1) begin
            failures++; $display("FAIL done_latch filt=%h fv=%b expected 0f00/1", filt_out, filt_valid_out);
        end
        tick();
        checks++;
        if (filt_valid_out !== 1'b0 || ready_out !== 1'b0 || timeout_out !== 1'b0) begin
            failures++; $display("FAIL done_pulse fv=%b ready=%b to=%b expected 0/0/0", filt_valid_out, ready_out, timeout_out);
        end
    endtask

    task automatic test_wrap();
        logic [5:0] exp_off;
        apply_reset();
        for (int k = 1; k <= 65; k++) begin
            sample_valid_in = 1'b1;
            sample_in       = 16'sh0100 + 16'(k);
            tick();
            sample_valid_in = 1'b0;
            exp_off = 6'(k % 64);
            checks++;
            if (offset_out !== exp_off || ready_out !== 1'b1) begin
                failures++; $display("FAIL wrap_offset k=%0d offset=%0d ready=%b expected %0d/1", k, offset_out, ready_out, exp_off);
            end
            tick();
            done_in = 1'b1;
            tick();
            done_in = 1'b0;
        end
        checks++;
        if (sample_out[0] !== 16'sh0140 || sample_out[1] !== 16'sh0141 || sample_out[63] !== 16'sh013F) begin
            failures++; $display("FAIL wrap_ring s0=%h s1=%h s63=%h expected 0140/0141/013f",
                                 sample_out[0], sample_out[1], sample_out[63]);
        end
    endtask

    task automatic test_overrun();
        apply_reset();
        sample_valid_in = 1'b1; sample_in = 16'sh00AA;
        tick();                                  // A committed, START
        sample_valid_in = 1'b0;
        tick();                                  // WAIT_DONE
        sample_valid_in = 1'b1; sample_in = 16'sh00BB;
        tick();                                  // B pending
        sample_in = 16'sh00CC;
        tick();                                  // C dropped
        sample_valid_in = 1'b0;
        checks++;
        if (overrun_out !== 1'b1 || overrun_cnt_out !== 8'd1) begin
            failures++; $display("FAIL overrun_pulse ov=%b cnt=%0d expected 1/1", overrun_out, overrun_cnt_out);
        end
        checks++;
        if (offset_out !== 6'd1 || sample_out[2] !== 16'sh0) begin
            failures++; $display("FAIL overrun_stable offset=%0d s2=%h expected 1/0000", offset_out, sample_out[2]);
        end
        tick();
        checks++;
        if (overrun_out !== 1'b0) begin failures++; $display("FAIL overrun_width got=%b expected=0", overrun_out); end
        done_in = 1'b1; filt_in = 16'sh0ABC;
        tick();
        done_in = 1'b0;
        checks++;
        if (offset_out !== 6'd2 || sample_out[2] !== 16'sh00BB || ready_out !== 1'b1 || filt_valid_out !== 1'b1) begin
            failures++; $display("FAIL overrun_pending offset=%0d s2=%h ready=%b fv=%b expected 2/00bb/1/1",
                                 offset_out, sample_out[2], ready_out, filt_valid_out);
        end
        tick();
        done_in = 1'b1; filt_in = 16'sh0BCD;
        tick();
        done_in = 1'b0;
        checks++;
        if (ready_out !== 1'b0 || filt_out !== 16'sh0BCD) begin
            failures++; $display("FAIL overrun_idle ready=%b filt=%h expected 0/0bcd", ready_out, filt_out);
        end
    endtask

    task automatic test_timeout();
        int n;
        bit seen_fv;
        sample_valid_in = 1'b1; sample_in = 16'sh0DDD;
        tick();
        sample_valid_in = 1'b0;
        n = 0;
        seen_fv = 1'b0;
        // Ready cycle, then WAIT_DONE counts 0..127; the 128th value triggers, pulse shows one edge later.
        while (timeout_out !== 1'b1 && n < 300) begin
            tick();
            n++;
            if (filt_valid_out === 1'b1) seen_fv = 1'b1;
        end
        checks++;
        if (n != 129) begin failures++; $display("FAIL timeout_latency cycles=%0d expected=129", n); end
        checks++;
        if (filt_out !== 16'sh0BCD || seen_fv || offset_out !== 6'd3) begin
            failures++; $display("FAIL timeout_hold filt=%h fv_seen=%b offset=%0d expected 0bcd/0/3", filt_out, seen_fv, offset_out);
        end
        tick();
        done_in = 1'b1; filt_in = 16'sh7777;
        tick();
        done_in = 1'b0;
        checks++;
        if (timeout_out !== 1'b0 || filt_valid_out !== 1'b0 || filt_out !== 16'sh0BCD || ready_out !== 1'b0) begin
            failures++; $display("FAIL idle_done_ignored to=%b fv=%b filt=%h ready=%b expected 0/0/0bcd/0",
                                 timeout_out, filt_valid_out, filt_out, ready_out);
        end
        sample_valid_in = 1'b1; sample_in = 16'sh0EEE;
        tick();
        sample_valid_in = 1'b0;
        checks++;
        if (ready_out !== 1'b1 || offset_out !== 6'd4) begin
            failures++; $display("FAIL timeout_to_idle ready=%b offset=%0d expected 1/4", ready_out, offset_out);
        end
        tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        sample_valid_in = 1'b1; sample_in = 16'sh0E0E;
        tick();                                  // E committed at 5
        sample_in = 16'sh0F0F;
        tick();                                  // F pending during START
        sample_valid_in = 1'b0;
        done_in = 1'b1; sample_valid_in = 1'b1; sample_in = 16'sh0606; filt_in = 16'sh0111;
        tick();                                  // F committed, G pending
        done_in = 1'b0; sample_valid_in = 1'b0;
        checks++;
        if (offset_out !== 6'd6 || sample_out[6] !== 16'sh0F0F || ready_out !== 1'b1 ||
            overrun_out !== 1'b0 || overrun_cnt_out !== 8'd1) begin
            failures++; $display("FAIL b2b_commit offset=%0d s6=%h ready=%b ov=%b cnt=%0d expected 6/0f0f/1/0/1",
                                 offset_out, sample_out[6], ready_out, overrun_out, overrun_cnt_out);
        end
        tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
        checks++;
        if (offset_out !== 6'd7 || sample_out[7] !== 16'sh0606 || ready_out !== 1'b1) begin
            failures++; $display("FAIL b2b_second offset=%0d s7=%h ready=%b expected 7/0606/1", offset_out, sample_out[7], ready_out);
        end
        tick();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        sample_valid_in = 1'b1; sample_in = 16'sh0123;
        tick();
        sample_valid_in = 1'b0;
        tick();
        sample_valid_in = 1'b1; sample_in = 16'sh0456;
        tick();
        sample_in = 16'sh0789;
        tick();
        sample_valid_in = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        checks++;
        if (offset_out !== 6'd0 || sample_out[8] !== 16'sh0 || sample_out[1] !== 16'sh0 || filt_out !== 16'sh0 ||
            overrun_out !== 1'b0 || overrun_cnt_out !== 8'd0 || ready_out !== 1'b0) begin
            failures++; $display("FAIL async_reset offset=%0d s8=%h s1=%h filt=%h ov=%b cnt=%0d ready=%b expected all 0",
                                 offset_out, sample_out[8], sample_out[1], filt_out, overrun_out, overrun_cnt_out, ready_out);
        end
        tick();
        rst_n_in = 1'b1;
        done_in = 1'b1; filt_in = 16'sh5555;
        tick();
        done_in = 1'b0;
        checks++;
        if (filt_valid_out !== 1'b0 || filt_out !== 16'sh0 || offset_out !== 6'd0 || ready_out !== 1'b0) begin
            failures++; $display("FAIL reset_discard fv=%b filt=%h offset=%0d ready=%b expected 0/0000/0/0",
                                 filt_valid_out, filt_out, offset_out, ready_out);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single_sample();
        test_done();
        test_wrap();
        test_overrun();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
